// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and the unified ram: one request at a time, stalls while busy.
// Optional build macro MISALIGN_TRAP_EN adds misaligned-access trapping (misalign_exc / exc_addr).
//   state    | meaning
//   S_IDLE   | ready for a request
//   S_ACCESS | ram port driven (RD_WAIT cycles for loads, 1 for stores)
//   S_RESP   | one-cycle completion pulse to writeback
module mem_access_unit #(
  parameter int                XLEN      = 32,
  parameter int                RD_WAIT   = 1,
  parameter logic [XLEN-1:0]   MEM_BASE  = '0,
  parameter logic [15:0]       MEM_DEPTH = 16'hffff
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            stall,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_rd,
  output logic            access_fault,
  output logic            ram_en,
  output logic            read_flag,
  output logic [XLEN-1:0] read_addr,
  input  logic [XLEN-1:0] read_data,
  output logic            write_flag,
  output logic [XLEN-1:0] write_addr,
  output logic [XLEN-1:0] write_data,
  output logic [2:0]      write_size
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            misalign_exc,
  output logic [XLEN-1:0] exc_addr
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  localparam int CW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  // Highest offset whose four bytes all lie inside the window.
  localparam logic [XLEN:0] LAST_OFF = (XLEN+1)'(MEM_DEPTH) - (XLEN+1)'(4);

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_q;
  logic            is_store_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic            fault_q;
  logic [XLEN-1:0] resp_data_q;
  logic [XLEN-1:0] load_ext;
  logic [XLEN:0]   addr_off;
  logic            in_range;
  logic            misalign;
  logic            accept;
  logic            store_ok;

  assign accept   = req_valid && req_ready;
  assign addr_off = {1'b0, req_addr} - {1'b0, MEM_BASE};
  assign in_range = !addr_off[XLEN] && (addr_off <= LAST_OFF);
  assign store_ok = (funct3_q == 3'b000) || (funct3_q == 3'b001) || (funct3_q == 3'b010);

`ifdef MISALIGN_TRAP_EN
  logic            mis_q;
  logic [XLEN-1:0] addr_q;
  logic            is_half, is_word;

  always_comb begin
    is_half = 1'b0;
    is_word = 1'b0;
    if (req_is_store) begin
      is_half = (req_funct3 == 3'b001);
      is_word = (req_funct3 == 3'b010);
    end else begin
      // undefined load encodings behave as LW, so funct3[1] marks a word
      is_half = (req_funct3[1:0] == 2'b01);
      is_word = req_funct3[1];
    end
    misalign = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
  end

  assign misalign_exc = (state_q == S_RESP) && mis_q;
  assign exc_addr     = misalign_exc ? addr_q : '0;
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = (!in_range || misalign) ? S_RESP : S_ACCESS;
      S_ACCESS: if (wait_q == '0) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{(XLEN-8){read_data[7]}}, read_data[7:0]};
      3'b001:  load_ext = {{(XLEN-16){read_data[15]}}, read_data[15:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, read_data[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, read_data[15:0]};
      default: load_ext = read_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      is_store_q  <= 1'b0;
      funct3_q    <= '0;
      rd_q        <= '0;
      fault_q     <= 1'b0;
      resp_data_q <= '0;
      read_addr   <= '0;
      write_addr  <= '0;
      write_data  <= '0;
      write_size  <= '0;
`ifdef MISALIGN_TRAP_EN
      mis_q       <= 1'b0;
      addr_q      <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_store_q  <= req_is_store;
        funct3_q    <= req_funct3;
        rd_q        <= req_rd;
        fault_q     <= !in_range;
        resp_data_q <= '0;
        wait_q      <= req_is_store ? '0 : CW'(RD_WAIT - 1);
`ifdef MISALIGN_TRAP_EN
        mis_q       <= misalign;
        addr_q      <= req_addr;
`endif
        // ram-side outputs only move when an access is really issued
        if (state_d == S_ACCESS) begin
          if (req_is_store) begin
            write_addr <= req_addr;
            write_data <= req_wdata;
            write_size <= req_funct3;
          end else begin
            read_addr  <= req_addr;
          end
        end
      end else if (state_q == S_ACCESS) begin
        if (wait_q != '0) wait_q <= wait_q - CW'(1);
        else if (!is_store_q) resp_data_q <= load_ext;
      end
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign stall        = !req_ready;
  assign ram_en       = (state_q == S_ACCESS);
  assign read_flag    = ram_en && !is_store_q;
  assign write_flag   = ram_en && is_store_q && store_ok;
  assign resp_valid   = (state_q == S_RESP);
  assign resp_data    = resp_valid ? resp_data_q : '0;
  assign resp_rd      = (resp_valid && !is_store_q) ? rd_q : '0;
  assign access_fault = resp_valid && fault_q;

endmodule
